vga_mode_ctrl: RTL and testbench

Mode-switch controller for the VGA timing generator. Holds a 4-entry video-mode table, drives the generator's timing parameters and reset, and accepts mode-change requests over a valid/ready handshake. A switch takes effect only at a frame boundary. The controller holds the generator in reset while parameters change, and mutes RGB until one clean frame of the new mode has completed.

---
 rtl/vga_mode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_ctrl.sv
// Mode-switch controller for the VGA timing generator.
// Holds a four-entry mode table. Mode changes are applied only at a frame
// boundary, and the generator is held in reset while its parameters change.
// RGB stays muted until the new mode has produced MUTE_FRAMES complete frames.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | active mode is stable; new requests are accepted
// WAIT_EOF  | request latched; RGB muted; waiting for end of current frame
// HOLD      | generator held in reset; new parameters load on last cycle
// MUTE      | generator running in the new mode; counting clean frames
module vga_mode_ctrl #(
    parameter int unsigned DEFAULT_MODE  = 0,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MUTE_FRAMES   = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_ready,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic        tg_rst,
    output logic [10:0] hd,
    output logic [10:0] hf,
    output logic [10:0] hr,
    output logic [10:0] hb,
    output logic [10:0] vd,
    output logic [10:0] vf,
    output logic [10:0] vr,
    output logic [10:0] vb,
    output logic [10:0] hmax,
    output logic [10:0] vmax,
    output logic        rgb_mute,
    output logic [1:0]  cur_mode,
    output logic        done
);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT_EOF, ST_HOLD, ST_MUTE} state_t;

    typedef struct packed {
        logic [10:0] hd, hf, hr, hb, vd, vf, vr, vb;
    } mode_t;

    localparam logic [1:0] DEF_MODE   = 2'(DEFAULT_MODE);
    localparam logic [7:0] SETTLE_INI = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MUTE_INI   = 4'(MUTE_FRAMES - 1);

    function automatic mode_t mode_lookup(input logic [1:0] m);
        mode_t t;
        case (m)
            2'd1:    t = '{11'd640,  11'd16, 11'd96,  11'd48,  11'd480,  11'd10, 11'd2, 11'd33};
            2'd2:    t = '{11'd800,  11'd40, 11'd128, 11'd88,  11'd600,  11'd1,  11'd4, 11'd23};
            2'd3:    t = '{11'd1024, 11'd24, 11'd136, 11'd160, 11'd768,  11'd3,  11'd6, 11'd29};
            default: t = '{11'd1280, 11'd48, 11'd112, 11'd248, 11'd1024, 11'd1,  11'd3, 11'd38};
        endcase
        return t;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    mode_t       r_par;
    logic [10:0] r_hmax;
    logic [10:0] r_vmax;
    logic [1:0]  r_cur_mode;
    logic [1:0]  r_pend_mode;
    logic [7:0]  r_settle_cnt;
    logic [3:0]  r_mute_cnt;
    logic        r_done;

    mode_t       w_new;
    mode_t       w_def;
    logic        w_eof;
    logic        w_settle_tc;
    logic        w_mute_tc;
    logic        w_req_same;
    logic        w_req_new;

    assign w_new       = mode_lookup(r_pend_mode);
    assign w_def       = mode_lookup(DEF_MODE);
    assign w_eof       = (hcount == r_hmax) && (vcount == r_vmax);
    assign w_settle_tc = (r_settle_cnt == 8'd0);
    assign w_mute_tc   = (r_mute_cnt == 4'd0);
    assign w_req_same  = (r_state == ST_RUN) && cfg_valid && (cfg_mode == r_cur_mode);
    assign w_req_new   = (r_state == ST_RUN) && cfg_valid && (cfg_mode != r_cur_mode);

    // State register; reset re-enters HOLD so bring-up follows the switch path.
    always_ff @(posedge clk) begin
        if (Reset) r_state <= ST_HOLD;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_req_new)             w_state_nxt = ST_WAIT_EOF;
            ST_WAIT_EOF: if (w_eof)                 w_state_nxt = ST_HOLD;
            ST_HOLD:     if (w_settle_tc)           w_state_nxt = ST_MUTE;
            ST_MUTE:     if (w_eof && w_mute_tc)    w_state_nxt = ST_RUN;
            default:                                w_state_nxt = ST_HOLD;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cfg_ready = (r_state == ST_RUN);
        tg_rst    = (r_state == ST_HOLD);
        rgb_mute  = (r_state != ST_RUN);
    end

    // Settle down-counter; reloads whenever not in HOLD.
    always_ff @(posedge clk) begin
        if (Reset)                                r_settle_cnt <= SETTLE_INI;
        else if (r_state != ST_HOLD)              r_settle_cnt <= SETTLE_INI;
        else if (!w_settle_tc)                    r_settle_cnt <= r_settle_cnt - 8'd1;
    end

    // Mute frame down-counter; decrements on each eof while in MUTE.
    always_ff @(posedge clk) begin
        if (Reset)                                r_mute_cnt <= MUTE_INI;
        else if (r_state != ST_MUTE)              r_mute_cnt <= MUTE_INI;
        else if (w_eof && !w_mute_tc)             r_mute_cnt <= r_mute_cnt - 4'd1;
    end

    // Pending mode capture on an accepted distinct-mode request.
    always_ff @(posedge clk) begin
        if (Reset)          r_pend_mode <= DEF_MODE;
        else if (w_req_new) r_pend_mode <= cfg_mode;
    end

    // Active parameter set; only the last HOLD cycle updates it.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_par      <= w_def;
            r_hmax     <= w_def.hd + w_def.hf + w_def.hr + w_def.hb - 11'd1;
            r_vmax     <= w_def.vd + w_def.vf + w_def.vr + w_def.vb - 11'd1;
            r_cur_mode <= DEF_MODE;
        end else if ((r_state == ST_HOLD) && w_settle_tc) begin
            r_par      <= w_new;
            r_hmax     <= w_new.hd + w_new.hf + w_new.hr + w_new.hb - 11'd1;
            r_vmax     <= w_new.vd + w_new.vf + w_new.vr + w_new.vb - 11'd1;
            r_cur_mode <= r_pend_mode;
        end
    end

    // Completion pulse for same-mode requests and finished switches.
    always_ff @(posedge clk) begin
        if (Reset) r_done <= 1'b0;
        else       r_done <= w_req_same || ((r_state == ST_MUTE) && w_eof && w_mute_tc);
    end

    assign hd       = r_par.hd;
    assign hf       = r_par.hf;
    assign hr       = r_par.hr;
    assign hb       = r_par.hb;
    assign vd       = r_par.vd;
    assign vf       = r_par.vf;
    assign vr       = r_par.vr;
    assign vb       = r_par.vb;
    assign hmax     = r_hmax;
    assign vmax     = r_vmax;
    assign cur_mode = r_cur_mode;
    assign done     = r_done;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: default instance plus a
// SETTLE_CYCLES=1 / MUTE_FRAMES=3 instance.
`timescale 1ns/1ps
module tb_vga_mode_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        Reset = 1'b1, cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [10:0] hcount = '0, vcount = '0;
    logic        cfg_ready, tg_rst, rgb_mute, done;
    logic [10:0] hd, hf, hr, hb, vd, vf, vr, vb, hmax, vmax;
    logic [1:0]  cur_mode;

    // short-settle, three-frame-mute instance
    logic        b_Reset = 1'b1, b_cfg_valid = 1'b0;
    logic [1:0]  b_cfg_mode = 2'd0;
    logic [10:0] b_hcount = '0, b_vcount = '0;
    logic        b_cfg_ready, b_tg_rst, b_rgb_mute, b_done;
    logic [10:0] b_hd, b_hf, b_hr, b_hb, b_vd, b_vf, b_vr, b_vb, b_hmax, b_vmax;
    logic [1:0]  b_cur_mode;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    vga_mode_ctrl dut (
        .clk(clk), .Reset(Reset), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
        .cfg_ready(cfg_ready), .hcount(hcount), .vcount(vcount), .tg_rst(tg_rst),
        .hd(hd), .hf(hf), .hr(hr), .hb(hb), .vd(vd), .vf(vf), .vr(vr), .vb(vb),
        .hmax(hmax), .vmax(vmax), .rgb_mute(rgb_mute), .cur_mode(cur_mode), .done(done)
    );

    vga_mode_ctrl #(.DEFAULT_MODE(0), .SETTLE_CYCLES(1), .MUTE_FRAMES(3)) dut_b (
        .clk(clk), .Reset(b_Reset), .cfg_valid(b_cfg_valid), .cfg_mode(b_cfg_mode),
        .cfg_ready(b_cfg_ready), .hcount(b_hcount), .vcount(b_vcount), .tg_rst(b_tg_rst),
        .hd(b_hd), .hf(b_hf), .hr(b_hr), .hb(b_hb), .vd(b_vd), .vf(b_vf), .vr(b_vr), .vb(b_vb),
        .hmax(b_hmax), .vmax(b_vmax), .rgb_mute(b_rgb_mute), .cur_mode(b_cur_mode), .done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present an end-of-frame position to the default instance for one edge.
    task automatic eof_pulse(input logic [10:0] h, input logic [10:0] v);
        hcount = h;
        vcount = v;
        tick();
        hcount = '0;
        vcount = '0;
    endtask

    // Count consecutive cycles with tg_rst high, starting at the current cycle.
    task automatic hold_len(output int len);
        len = 0;
        while (tg_rst && len < 20) begin
            len++;
            tick();
        end
    endtask

    // Full distinct-mode switch on the default instance.
    task automatic switch_to(input logic [1:0] m,
                             input logic [10:0] old_h, input logic [10:0] old_v,
                             input logic [10:0] new_h, input logic [10:0] new_v);
        int len;
        cfg_valid = 1'b1;
        cfg_mode  = m;
        tick();
        cfg_valid = 1'b0;
        check("sw_ready_low", cfg_ready, 0);
        check("sw_mute_high", rgb_mute, 1);
        eof_pulse(old_h, old_v);
        hold_len(len);
        check("sw_hold_len", len, 4);
        check("sw_hmax", hmax, new_h);
        check("sw_vmax", vmax, new_v);
        check("sw_cur_mode", cur_mode, m);
        eof_pulse(new_h, new_v);
        check("sw_done", done, 1);
        check("sw_unmute", rgb_mute, 0);
        tick();
        check("sw_done_once", done, 0);
    endtask

    initial begin
        // ---- reset and bring-up to mode 0
        tick();
        tick();
        check("rst_tg_rst", tg_rst, 1);
        check("rst_mute", rgb_mute, 1);
        check("rst_ready", cfg_ready, 0);
        check("rst_done", done, 0);
        check("rst_cur_mode", cur_mode, 0);
        check("rst_hmax", hmax, 1687);
        check("rst_vmax", vmax, 1065);
        check("rst_hd", hd, 1280);
        check("rst_vb", vb, 38);
        Reset = 1'b0;
        hold_len(n);
        check("boot_hold_len", n, 4);
        check("boot_mute", rgb_mute, 1);
        check("boot_ready", cfg_ready, 0);
        tick();
        check("boot_wait_no_done", done, 0);
        eof_pulse(11'd1687, 11'd1065);
        check("boot_done", done, 1);
        check("boot_ready_up", cfg_ready, 1);
        check("boot_unmute", rgb_mute, 0);
        tick();
        check("boot_done_once", done, 0);

        // ---- mode 0 -> 1 requested mid-frame
        hcount = 11'd100;
        vcount = 11'd50;
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        tick();
        cfg_valid = 1'b0;
        check("m1_mute_next", rgb_mute, 1);
        check("m1_ready_low", cfg_ready, 0);
        check("m1_tg_rst_low", tg_rst, 0);
        tick();
        tick();
        check("m1_hmax_kept", hmax, 1687);
        check("m1_mode_kept", cur_mode, 0);
        eof_pulse(11'd1687, 11'd1064);
        check("m1_near_eof", tg_rst, 0);
        eof_pulse(11'd1687, 11'd1065);
        check("m1_hold_start", tg_rst, 1);
        check("m1_hold_hmax_old", hmax, 1687);
        hold_len(n);
        check("m1_hold_len", n, 4);
        check("m1_hmax", hmax, 799);
        check("m1_vmax", vmax, 524);
        check("m1_cur_mode", cur_mode, 1);
        check("m1_hd", hd, 640);
        check("m1_hf", hf, 16);
        check("m1_hr", hr, 96);
        check("m1_hb", hb, 48);
        check("m1_vd", vd, 480);
        check("m1_vf", vf, 10);
        check("m1_vr", vr, 2);
        check("m1_vb", vb, 33);
        check("m1_mute_in_mute", rgb_mute, 1);
        eof_pulse(11'd799, 11'd524);
        check("m1_done", done, 1);
        check("m1_ready", cfg_ready, 1);
        tick();
        check("m1_done_once", done, 0);

        // ---- switch to mode 2, then same-mode request
        switch_to(2'd2, 11'd799, 11'd524, 11'd1055, 11'd627);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd2;
        tick();
        cfg_valid = 1'b0;
        check("same_done", done, 1);
        check("same_ready", cfg_ready, 1);
        check("same_tg_rst", tg_rst, 0);
        check("same_mute", rgb_mute, 0);
        check("same_hmax", hmax, 1055);
        tick();
        check("same_done_once", done, 0);
        check("same_vmax", vmax, 627);
        check("same_mode", cur_mode, 2);

        // ---- request 1, then hold request 3 through the pending switch
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        tick();
        cfg_mode  = 2'd3;
        tick();
        check("q_ready_low", cfg_ready, 0);
        eof_pulse(11'd1055, 11'd627);
        hold_len(n);
        check("q_hold_len", n, 4);
        check("q_first_mode", cur_mode, 1);
        check("q_first_hmax", hmax, 799);
        eof_pulse(11'd799, 11'd524);
        check("q_first_done", done, 1);
        check("q_ready_back", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("q_accepted", cfg_ready, 0);
        check("q_mute", rgb_mute, 1);
        eof_pulse(11'd799, 11'd524);
        hold_len(n);
        check("q_hold_len2", n, 4);
        check("q_mode3", cur_mode, 3);
        check("q_hmax3", hmax, 1343);
        check("q_vmax3", vmax, 805);
        eof_pulse(11'd1343, 11'd805);
        check("q_done2", done, 1);
        tick();

        // ---- back to 0, then reset during HOLD of 0 -> 3
        switch_to(2'd0, 11'd1343, 11'd805, 11'd1687, 11'd1065);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        tick();
        cfg_valid = 1'b0;
        eof_pulse(11'd1687, 11'd1065);
        tick();
        check("r_in_hold", tg_rst, 1);
        Reset = 1'b1;
        tick();
        check("r_tg_rst", tg_rst, 1);
        check("r_mute", rgb_mute, 1);
        check("r_ready", cfg_ready, 0);
        check("r_done", done, 0);
        check("r_mode", cur_mode, 0);
        check("r_hmax", hmax, 1687);
        Reset = 1'b0;
        hold_len(n);
        check("r_hold_len", n, 4);
        check("r_mode_after", cur_mode, 0);
        check("r_hmax_after", hmax, 1687);
        check("r_vmax_after", vmax, 1065);
        eof_pulse(11'd1687, 11'd1065);
        check("r_done_boot", done, 1);
        check("r_mode_final", cur_mode, 0);
        tick();

        // ---- SETTLE_CYCLES=1, MUTE_FRAMES=3 instance
        b_Reset = 1'b0;
        n = 0;
        while (b_tg_rst && n < 20) begin
            n++;
            tick();
        end
        check("b_hold_len", n, 1);
        check("b_hmax", b_hmax, 1687);
        for (int f = 0; f < 2; f++) begin
            b_hcount = 11'd1687;
            b_vcount = 11'd1065;
            tick();
            b_hcount = '0;
            b_vcount = '0;
            check("b_mute_hold", b_rgb_mute, 1);
            check("b_no_done", b_done, 0);
            check("b_tg_rst_low", b_tg_rst, 0);
            tick();
        end
        b_hcount = 11'd1687;
        b_vcount = 11'd1065;
        tick();
        b_hcount = '0;
        b_vcount = '0;
        check("b_done", b_done, 1);
        check("b_unmute", b_rgb_mute, 0);
        check("b_ready", b_cfg_ready, 1);
        tick();
        check("b_done_once", b_done, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
